flex_sample_counter: RTL
========================

Name: flex_sample_counter

Overview:
- Parametrised successor to the fixed 10-bit sample counter used by the filter datapath.
- Counts sample strobes up or down to a programmable terminal value, in wrap or saturate mode.
- Provides an aligned terminal flag, a one-cycle wrap pulse, and a sticky threshold flag. The threshold flag replaces the hard-coded "1000 samples seen" flag.
- Instantiated by the filter controller and any block that needs sample or bit counting.

Parameters:
- NUM_CNT_BITS, 10, width of the counter, rollover_val and thresh_val; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear; highest priority after reset.
- count_enable  input  1  advance the count by one this cycle.
- count_down  input  1  0 = count up, 1 = count down; sampled every enabled cycle.
- sat_mode  input  1  0 = wrap at terminal, 1 = saturate (hold) at terminal.
- rollover_val  input  NUM_CNT_BITS  upper terminal value, unsigned.
- thresh_val  input  NUM_CNT_BITS  threshold for thresh_flag, unsigned.
- count_out  output  NUM_CNT_BITS  current count, registered.
- term_flag  output  1  registered; high while count_out equals the active terminal value.
- wrap_pulse  output  1  registered; one-cycle pulse on the cycle after a wrap occurs.
- thresh_flag  output  1  registered and sticky; set once count_out >= thresh_val.

Behaviour:
- Reset: n_reset low forces count_out=0, wrap_pulse=0 and thresh_flag=0 immediately, without waiting for a clock edge.
- Reset value of term_flag: 1 if count_down=1, else (rollover_val==0). term_flag is a register, so this value holds from reset release until the first edge.
- Priority each edge: clear, then count_enable, then hold.
- clear=1: count_out<=0 and thresh_flag<=0. wrap_pulse<=0. term_flag follows the term rule below.
- Terminal value: rollover_val when count_down=0; 0 when count_down=1.
- Up count, enabled:
  - count_out < rollover_val: count_out+1.
  - count_out == rollover_val: next is 0 in wrap mode, with wrap_pulse<=1; holds in saturate mode.
  - count_out > rollover_val (rollover_val lowered mid-count): next is 0 in wrap mode, with wrap_pulse<=1; next is rollover_val in saturate mode, with no pulse.
- Down count, enabled:
  - count_out > 0: count_out-1, clamped to rollover_val if count_out > rollover_val.
  - count_out == 0: next is rollover_val in wrap mode, with wrap_pulse<=1; holds at 0 in saturate mode.
- Not enabled: count_out holds and wrap_pulse<=0.
- Term rule: term_flag is registered from the next-state count (next_count == terminal value), so it is cycle-aligned with count_out, with no extra latency.
- wrap_pulse: high for exactly one cycle per wrap event; never high two consecutive cycles unless wraps occur on consecutive enabled cycles (e.g. rollover_val=0 in wrap mode).
- thresh_flag: set on the edge where next_count >= thresh_val. Once set, it stays set until clear or reset, even if the count later falls below thresh_val or thresh_val changes. thresh_val=0 sets it on the first edge after reset release.
- rollover_val=0: the count stays 0. term_flag is 1. In wrap mode wrap_pulse fires on every enabled cycle; in saturate mode there is no pulse.
- Arithmetic: unsigned; no intermediate overflow. Wrap handling prevents count_out from exceeding 2^NUM_CNT_BITS-1.
- clear and count_enable together: clear wins; no count and no pulse.
- Reset mid-count: all state returns to reset values asynchronously. Counting resumes from 0 on the first enabled edge after n_reset rises.

Test Plan:
1. Reset and basic count: NUM_CNT_BITS=10, rollover_val=999, thresh_val=1000, up, wrap mode, assert n_reset low mid-count -> count_out=0, flags 0 immediately. Then run 1000 enabled cycles -> count_out 0..999 then 0; term_flag high exactly at 999; wrap_pulse high one cycle after the 999->0 edge; thresh_flag stays 0.
2. Threshold: thresh_val=500, 600 enables, then clear -> thresh_flag rises on the edge to count 500, stays high through 600, and drops with clear; count_out=0.
3. Saturate up and down: rollover_val=7, sat_mode=1, 10 enables up -> count_out holds 7, no wrap_pulse. Then count_down=1, 10 enables -> count_out reaches 0 and holds, term_flag=1.
4. Down wrap: rollover_val=5, sat_mode=0, count_down=1, starting from 0 -> sequence 5,4,3,2,1,0,5; wrap_pulse after each 0->5.
5. Mid-count rollover change: count at 12, rollover_val lowered to 8, then one enable -> count_out=0 with wrap_pulse in wrap mode; count_out=8 with no pulse in saturate mode.
6. Priority and corners: clear and count_enable asserted together -> count_out=0, no pulse. rollover_val=0 in wrap mode with 3 enables -> count_out=0 and wrap_pulse high for 3 consecutive cycles.

Source files
------------

// File: rtl/flex_sample_counter.sv
// Programmable up/down sample counter with wrap or saturate at a terminal value.
// Provides a cycle-aligned terminal flag, a one-cycle wrap pulse and a sticky threshold flag.
module flex_sample_counter #(
    parameter int NUM_CNT_BITS = 10
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic                    count_down,
    input  logic                    sat_mode,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    input  logic [NUM_CNT_BITS-1:0] thresh_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    term_flag,
    output logic                    wrap_pulse,
    output logic                    thresh_flag
);

    logic [NUM_CNT_BITS-1:0] next_count;
    logic [NUM_CNT_BITS-1:0] terminal;
    logic                    next_wrap;
    logic                    next_term;
    logic                    next_thresh;

    always_comb begin
        next_count = count_out;
        next_wrap  = 1'b0;
        if (clear) begin
            next_count = '0;
        end else if (count_enable) begin
            if (!count_down) begin
                if (count_out < rollover_val) begin
                    next_count = count_out + 1'b1;
                end else if (count_out == rollover_val) begin
                    if (!sat_mode) begin
                        next_count = '0;
                        next_wrap  = 1'b1;
                    end
                end else begin
                    // Terminal was lowered below the running count.
                    if (sat_mode) begin
                        next_count = rollover_val;
                    end else begin
                        next_count = '0;
                        next_wrap  = 1'b1;
                    end
                end
            end else begin
                if (count_out == '0) begin
                    if (!sat_mode) begin
                        next_count = rollover_val;
                        next_wrap  = 1'b1;
                    end
                end else if (count_out > rollover_val) begin
                    next_count = rollover_val;
                end else begin
                    next_count = count_out - 1'b1;
                end
            end
        end
    end

    always_comb begin
        terminal    = count_down ? '0 : rollover_val;
        next_term   = (next_count == terminal);
        next_thresh = clear ? 1'b0 : (thresh_flag | (next_count >= thresh_val));
    end

    // Registered outputs: flags derive from next_count so they align with count_out.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count_out   <= '0;
            wrap_pulse  <= 1'b0;
            thresh_flag <= 1'b0;
            term_flag   <= count_down | (rollover_val == '0);
        end else begin
            count_out   <= next_count;
            wrap_pulse  <= next_wrap;
            thresh_flag <= next_thresh;
            term_flag   <= next_term;
        end
    end

endmodule
